// File: rtl/instr_register_exec_if.sv
// Instruction-register write/read bus between the stimulus/checker side (master)
// and the instruction store (slave).
interface instr_register_exec_if #(
   parameter int unsigned OPW  = 32,
   parameter int unsigned RESW = 64,
   parameter int unsigned AW   = 5
);
   localparam int unsigned IW = 4 + 2 * OPW + RESW;

   logic                   load_en;
   logic [3:0]             opcode;
   logic signed [OPW-1:0]  operand_a;
   logic signed [OPW-1:0]  operand_b;
   logic [AW-1:0]          write_pointer;
   logic [AW-1:0]          read_pointer;
   logic [IW-1:0]          instruction_word;
   logic                   read_valid;
   logic [AW:0]            entry_count;
   logic                   div_zero_err;

   modport master (
      output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
      input  instruction_word, read_valid, entry_count, div_zero_err
   );

   modport slave (
      input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
      output instruction_word, read_valid, entry_count, div_zero_err
   );
endinterface

// File: rtl/instr_register_exec.sv
// Instruction store with a two-stage write pipeline: stage 1 captures operands,
// stage 2 computes the 64-bit result and marks the entry done.
module instr_register_exec #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned OPW   = 32,
   parameter int unsigned RESW  = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   instr_register_exec_if.slave   bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned IW = 4 + 2 * OPW + RESW;

   typedef enum logic [3:0] {
      OP_ZERO  = 4'd0,
      OP_PASSA = 4'd1,
      OP_PASSB = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_MULT  = 4'd5,
      OP_DIV   = 4'd6,
      OP_MOD   = 4'd7
   } opcode_e;

   typedef struct packed {
      logic [3:0]             opc;
      logic signed [OPW-1:0]  a;
      logic signed [OPW-1:0]  b;
      logic signed [RESW-1:0] res;
   } entry_t;

   entry_t                 mem_q [DEPTH];
   logic [DEPTH-1:0]       done_q;

   logic                   s2_valid_q, s2_valid_d;
   logic [AW-1:0]          s2_ptr_q;
   logic [3:0]             s2_opc_q;
   logic signed [OPW-1:0]  s2_a_q, s2_b_q;

   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic [IW-1:0]          iw_q;
   logic                   rv_q;

   logic signed [RESW-1:0] a_ext, b_ext, res_c;
   logic                   dz_c, hazard_c, complete_c, inc_c, dec_c;

   // Stage-2 arithmetic on sign-extended operands
   always_comb begin
      a_ext = RESW'(s2_a_q);
      b_ext = RESW'(s2_b_q);
      res_c = '0;
      dz_c  = 1'b0;
      case (s2_opc_q)
         OP_ZERO:  res_c = '0;
         OP_PASSA: res_c = a_ext;
         OP_PASSB: res_c = b_ext;
         OP_ADD:   res_c = a_ext + b_ext;
         OP_SUB:   res_c = a_ext - b_ext;
         OP_MULT:  res_c = a_ext * b_ext;
         OP_DIV:   if (b_ext == '0) dz_c = 1'b1; else res_c = a_ext / b_ext;
         OP_MOD:   if (b_ext == '0) dz_c = 1'b1; else res_c = a_ext % b_ext;
         default:  res_c = '0;
      endcase
   end

   // A stage-1 rewrite of the entry stage 2 is finishing wins; stage 2 is dropped
   always_comb begin
      hazard_c   = s2_valid_q && bus.load_en && (bus.write_pointer == s2_ptr_q);
      complete_c = s2_valid_q && !hazard_c;
      inc_c      = complete_c && !done_q[s2_ptr_q];
      dec_c      = bus.load_en && done_q[bus.write_pointer];
      cnt_d      = cnt_q;
      if (inc_c && !dec_c && (cnt_q != CW'(DEPTH))) begin
         cnt_d = cnt_q + CW'(1);
      end else if (dec_c && !inc_c && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
      err_d      = err_q | (s2_valid_q & dz_c);
      s2_valid_d = bus.load_en;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         done_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_ptr_q   <= '0;
         s2_opc_q   <= '0;
         s2_a_q     <= '0;
         s2_b_q     <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         iw_q       <= '0;
         rv_q       <= 1'b0;
      end else begin
         s2_valid_q <= s2_valid_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         iw_q       <= mem_q[bus.read_pointer];
         rv_q       <= done_q[bus.read_pointer];
         if (complete_c) begin
            mem_q[s2_ptr_q].res <= res_c;
            done_q[s2_ptr_q]    <= 1'b1;
         end
         if (bus.load_en) begin
            mem_q[bus.write_pointer].opc <= bus.opcode;
            mem_q[bus.write_pointer].a   <= bus.operand_a;
            mem_q[bus.write_pointer].b   <= bus.operand_b;
            done_q[bus.write_pointer]    <= 1'b0;
            s2_ptr_q                     <= bus.write_pointer;
            s2_opc_q                     <= bus.opcode;
            s2_a_q                       <= bus.operand_a;
            s2_b_q                       <= bus.operand_b;
         end
      end
   end

   assign bus.instruction_word = iw_q;
   assign bus.read_valid       = rv_q;
   assign bus.entry_count      = cnt_q;
   assign bus.div_zero_err     = err_q;
endmodule

// File: tb/tb_instr_register_exec.sv
// Directed bench for instr_register_exec: opcode table plus latency, hazard,
// divide-by-zero, full-store and reset sequences.
module tb_instr_register_exec;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   instr_register_exec_if bus ();

   instr_register_exec dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  ptr;
      logic [3:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_wr(input logic [4:0] p, input logic [3:0] o,
                           input logic [31:0] a, input logic [31:0] b);
      bus.load_en       = 1'b1;
      bus.write_pointer = p;
      bus.opcode        = o;
      bus.operand_a     = a;
      bus.operand_b     = b;
   endtask

   task automatic read_chk(input string nm, input logic [4:0] p, input logic [3:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] r, input logic v);
      bus.read_pointer = p;
      tick();
      chk({nm, ".word"}, bus.instruction_word, {o, a, b, r});
      chk({nm, ".valid"}, 132'(bus.read_valid), 132'(v));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      vt[0]  = '{5'd0,  4'd0,  -32'sd7, 32'sd3, 64'sd0};
      vt[1]  = '{5'd1,  4'd1,  -32'sd7, 32'sd3, -64'sd7};
      vt[2]  = '{5'd2,  4'd2,  -32'sd7, 32'sd3, 64'sd3};
      vt[3]  = '{5'd3,  4'd3,  -32'sd7, 32'sd3, -64'sd4};
      vt[4]  = '{5'd4,  4'd4,  -32'sd7, 32'sd3, -64'sd10};
      vt[5]  = '{5'd5,  4'd5,  -32'sd7, 32'sd3, -64'sd21};
      vt[6]  = '{5'd6,  4'd6,  -32'sd7, 32'sd3, -64'sd2};
      vt[7]  = '{5'd7,  4'd7,  -32'sd7, 32'sd3, -64'sd1};
      vt[8]  = '{5'd10, 4'd5,  32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
      vt[9]  = '{5'd11, 4'd5,  32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000};
      vt[10] = '{5'd12, 4'd12, 32'sd5, 32'sd6, 64'sd0};
      vt[11] = '{5'd13, 4'd6,  32'sd7, -32'sd2, -64'sd3};
      vt[12] = '{5'd14, 4'd7,  32'sd7, -32'sd2, 64'sd1};

      reset             = 1'b1;
      bus.load_en       = 1'b0;
      bus.opcode        = '0;
      bus.operand_a     = '0;
      bus.operand_b     = '0;
      bus.write_pointer = '0;
      bus.read_pointer  = '0;
      tick();
      tick();
      chk("rst.word",  bus.instruction_word, '0);
      chk("rst.valid", 132'(bus.read_valid), 132'(0));
      chk("rst.count", 132'(bus.entry_count), 132'(0));
      chk("rst.err",   132'(bus.div_zero_err), 132'(0));
      reset = 1'b0;

      // Opcode table, written back-to-back then read back
      for (int i = 0; i < NV; i++) begin
         drive_wr(vt[i].ptr, vt[i].opc, vt[i].a, vt[i].b);
         tick();
      end
      bus.load_en = 1'b0;
      tick();
      tick();
      chk("table.count", 132'(bus.entry_count), 132'(NV));
      chk("table.err",   132'(bus.div_zero_err), 132'(0));
      for (int i = 0; i < NV; i++) begin
         read_chk($sformatf("table[%0d]", i), vt[i].ptr, vt[i].opc, vt[i].a, vt[i].b,
                  vt[i].res, 1'b1);
      end

      // Write-to-read latency
      drive_wr(5'd20, 4'd3, 32'sd100, 32'sd23);
      bus.read_pointer = 5'd20;
      tick();
      chk("lat.valid0", 132'(bus.read_valid), 132'(0));
      bus.load_en = 1'b0;
      read_chk("lat.n1", 5'd20, 4'd3, 32'sd100, 32'sd23, 64'sd0, 1'b0);
      chk("lat.count", 132'(bus.entry_count), 132'(14));
      read_chk("lat.n2", 5'd20, 4'd3, 32'sd100, 32'sd23, 64'sd123, 1'b1);

      // Divide / modulo by zero and sticky error
      drive_wr(5'd9, 4'd6, 32'sd15, 32'sd0);
      tick();
      bus.load_en = 1'b0;
      bus.read_pointer = 5'd9;
      tick();
      chk("dz.err", 132'(bus.div_zero_err), 132'(1));
      chk("dz.count", 132'(bus.entry_count), 132'(15));
      read_chk("dz.div", 5'd9, 4'd6, 32'sd15, 32'sd0, 64'sd0, 1'b1);
      drive_wr(5'd22, 4'd7, 32'sd5, 32'sd0);
      tick();
      bus.load_en = 1'b0;
      tick();
      read_chk("dz.mod", 5'd22, 4'd7, 32'sd5, 32'sd0, 64'sd0, 1'b1);
      drive_wr(5'd21, 4'd3, 32'sd1, 32'sd1);
      tick();
      bus.load_en = 1'b0;
      tick();
      tick();
      chk("dz.sticky", 132'(bus.div_zero_err), 132'(1));
      chk("dz.count2", 132'(bus.entry_count), 132'(17));

      // Same-address hazard on entry 4 (previously complete)
      drive_wr(5'd4, 4'd3, 32'sd1, 32'sd2);
      tick();
      chk("hz.count_n", 132'(bus.entry_count), 132'(16));
      drive_wr(5'd4, 4'd4, 32'sd10, 32'sd4);
      tick();
      chk("hz.count_n1", 132'(bus.entry_count), 132'(16));
      bus.load_en = 1'b0;
      bus.read_pointer = 5'd4;
      tick();
      chk("hz.valid_n2", 132'(bus.read_valid), 132'(0));
      tests++;
      if (bus.instruction_word[63:0] === 64'd3) begin
         fails++;
         $display("FAIL hz.no3: got rezultat %h required anything but 3", bus.instruction_word[63:0]);
      end
      chk("hz.count_n2", 132'(bus.entry_count), 132'(17));
      read_chk("hz.n3", 5'd4, 4'd4, 32'sd10, 32'sd4, 64'sd6, 1'b1);
      chk("hz.count_n3", 132'(bus.entry_count), 132'(17));

      // Fill all entries, overwrite entry 0
      for (int i = 0; i < 32; i++) begin
         if (i == 31) drive_wr(5'd31, 4'd12, 32'sd5, 32'sd6);
         else         drive_wr(5'(i), 4'd3, 32'(i), 32'sd1);
         tick();
      end
      bus.load_en = 1'b0;
      tick();
      tick();
      chk("full.count", 132'(bus.entry_count), 132'(32));
      drive_wr(5'd0, 4'd3, 32'sd7, 32'sd7);
      tick();
      chk("ovw.count31", 132'(bus.entry_count), 132'(31));
      bus.load_en = 1'b0;
      tick();
      chk("ovw.count32", 132'(bus.entry_count), 132'(32));
      read_chk("full.illegal", 5'd31, 4'd12, 32'sd5, 32'sd6, 64'sd0, 1'b1);
      read_chk("full.e0", 5'd0, 4'd3, 32'sd7, 32'sd7, 64'sd14, 1'b1);
      read_chk("full.e17", 5'd17, 4'd3, 32'sd17, 32'sd1, 64'sd18, 1'b1);

      // Reset mid-stream while entry 3 is in flight
      bus.read_pointer = 5'd3;
      drive_wr(5'd3, 4'd3, 32'sd1, 32'sd2);
      tick();
      chk("mid.pre_valid", 132'(bus.read_valid), 132'(1));
      #2 reset = 1'b1;
      #1;
      chk("mid.word",  bus.instruction_word, '0);
      chk("mid.valid", 132'(bus.read_valid), 132'(0));
      chk("mid.count", 132'(bus.entry_count), 132'(0));
      chk("mid.err",   132'(bus.div_zero_err), 132'(0));
      bus.load_en = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      read_chk("mid.read3", 5'd3, 4'd0, 32'd0, 32'd0, 64'd0, 1'b0);
      chk("mid.count_a", 132'(bus.entry_count), 132'(0));
      tick();
      chk("mid.count_b", 132'(bus.entry_count), 132'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_register_exec.md
# instr_register_exec

Responder side of the instruction-register write/read interface. A 32-entry instruction store that accepts opcode/operand writes from the stimulus side, computes each entry's 64-bit result in a second pipeline stage, and returns the full instruction word (opcode, operands, result) with a per-entry valid flag on a registered read port. It sits between the instruction generator and the checker, which compares its read-back against a locally computed expected result.

## Interface
Parameters:
- DEPTH, 32, number of entries (power of two); address width = log2(DEPTH) = 5.
- OPW, 32, operand width, signed two's complement.
- RESW, 64, result width, signed.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset; asserts immediately, released synchronously by the driver.
- load_en  in  1  write strobe, sampled at rising edge.
- opcode  in  4  ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7; 8–15 illegal.
- operand_a  in  OPW  signed operand A.
- operand_b  in  OPW  signed operand B.
- write_pointer  in  5  entry written when load_en=1.
- read_pointer  in  5  entry to return on the next edge.
- instruction_word  out  4+2·OPW+RESW  {opc, operand_a, operand_b, rezultat}, registered.
- read_valid  out  1  returned entry was written and its result is complete.
- entry_count  out  6  number of entries holding a completed result, 0..32.
- div_zero_err  out  1  sticky: set when a DIV or MOD with operand_b=0 is executed.

## Operation
- Stage 1 (edge N, load_en=1): store opc, operand_a, operand_b into entry[write_pointer]; clear its done bit; capture {ptr, opc, a, b} into the stage-2 register and set s2_valid.
- Stage 2 (edge N+1, s2_valid=1): compute result, write entry[s2_ptr].rezultat, set done bit. s2_valid clears unless another stage-1 write occurs on the same edge.
- Arithmetic, operands sign-extended to RESW before the operation:
  - ZERO → 0.
  - PASSA → a.
  - PASSB → b.
  - ADD → a+b.
  - SUB → a−b.
  - MULT → full signed 64-bit product.
  - DIV → a/b, truncating toward zero.
  - MOD → a%b, sign follows a.
  - DIV or MOD with b=0 → result 0 and div_zero_err set.
  - Illegal opcodes → result 0, no error.
- Read port, each edge: instruction_word ← entry[read_pointer]; read_valid ← done[read_pointer]. Both use pre-edge array state.
- entry_count: +1 when stage 2 sets a done bit that was 0. −1 when stage 1 clears a done bit that was 1. Both on one edge for different entries → net 0. Saturates at 32 and never underflows.
- Same-address hazard: stage-1 write to the address stage 2 is completing on the same edge. Stage 2's result is discarded, the done bit stays 0, and the new write proceeds. Stage 2 never writes an entry rewritten after its capture.
- Back-to-back writes every cycle are supported; throughput is 1 instruction per cycle.

## Timing
- Reset (async, active-high):
  - All entries 0, all done bits 0, s2_valid=0.
  - instruction_word=0, read_valid=0, entry_count=0, div_zero_err=0.
  - Any in-flight stage-2 op is dropped.
- Write at edge N, read of the same address presented before edge N+1: instruction_word shows the operands, rezultat=0 or stale, read_valid=0.
- Same read presented before edge N+2: full result, read_valid=1. Write-to-valid-read latency is 2 edges.
- Read latency: 1 edge from read_pointer to instruction_word.
- entry_count and div_zero_err update on edge N+1, in the same edge as the done bit.

## Test plan
- Reset mid-stream: write entry 3 at edge N, assert reset between N and N+1 → all outputs 0 immediately. Reading entry 3 after release gives instruction_word=0, read_valid=0, entry_count=0.
- All opcodes: write a=−7, b=3 with opcodes 0..7 to entries 0..7, then read 0..7 → results 0, −7, 3, −4, −10, −21, −2, −1. read_valid=1 for each; entry_count=8.
- Divide by zero: write DIV a=15, b=0 to entry 9 → rezultat=0 and div_zero_err=1, which stays 1 through later legal writes until reset. MOD a=5, b=0 behaves the same.
- Wide multiply: MULT a=32'h7FFFFFFF, b=32'h7FFFFFFF → rezultat=64'h3FFFFFFF00000001. MULT a=−2^31, b=−1 → 2^31.
- Pipeline hazard: ADD 1+2 to entry 4 at edge N, SUB 10−4 to entry 4 at edge N+1 → entry 4 never shows 3. Read at N+2 gives read_valid=0; read at N+3 gives rezultat=6, read_valid=1; entry_count increments by exactly 1.
- Full and overwrite: write all 32 entries back-to-back → entry_count=32 two edges after the last write. Rewriting entry 0 drops entry_count to 31 for one cycle, then 32 again. Illegal opcode 12 → result 0, no error flag.
